// File: rtl/mmio_pwm_led.sv
// Memory-mapped 4-channel PWM (led/red/green/blue) with double-buffered duties applied at period wrap.
// Latency: rdata one cycle after the address, PWM outputs registered one cycle after cnt; no backpressure.
module mmio_pwm_led #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int          PWM_BITS   = 8,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int                  NCH       = 4;
  localparam logic [31:0]         LAST_ADDR = BASE_ADDR + 32'h1C;
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_DUTY_LED = 3'd2;
  localparam logic [2:0] OFF_DUTY_R   = 3'd3;
  localparam logic [2:0] OFF_DUTY_G   = 3'd4;
  localparam logic [2:0] OFF_DUTY_B   = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  logic [31:0]           offset;
  logic [2:0]            word;
  logic [2:0]            duty_off;
  logic [1:0]            duty_idx;
  logic                  wr_en;
  logic                  duty_wr;
  logic                  prescale_wr;
  logic                  tick;
  logic                  wrap;
  logic [31:0]           cnt_ext;
  logic [7:0]            status_cnt;
  logic                  unused_bits;

  logic                  en_q,       en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
  logic [PWM_BITS-1:0]   cnt_q,      cnt_d;
  logic [PWM_BITS:0]     shadow_q [NCH];
  logic [PWM_BITS:0]     shadow_d [NCH];
  logic [PWM_BITS:0]     active_q [NCH];
  logic [PWM_BITS:0]     active_d [NCH];
  logic                  pending_q,  pending_d;
  logic [NCH-1:0]        out_q,      out_d;
  logic [31:0]           rdata_q,    rdata_d;

  // Address decode: word index within the 32-byte window, byte lanes ignored.
  assign offset      = addr - BASE_ADDR;
  assign word        = offset[4:2];
  assign sel         = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign wr_en       = we && sel;
  assign prescale_wr = wr_en && (word == OFF_PRESCALE);
  assign duty_wr     = wr_en && (word >= OFF_DUTY_LED) && (word <= OFF_DUTY_B);
  assign duty_off    = word - OFF_DUTY_LED;
  assign duty_idx    = duty_off[1:0];

  assign tick        = en_q && (pcnt_q == prescale_q);
  assign wrap        = tick && (cnt_q == CNT_MAX);

  assign cnt_ext     = 32'(cnt_q);
  assign status_cnt  = cnt_ext[7:0];
  assign unused_bits = ^{offset[31:5], offset[1:0], cnt_ext[31:8], duty_off[2]};

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    if (wr_en && (word == OFF_CTRL)) begin
      en_d = wdata[0];
    end
    if (prescale_wr) begin
      prescale_d = wdata[PRESCALE_W-1:0];
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!en_q || prescale_wr || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
    if (!en_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + PWM_BITS'(1);
    end
  end

  // Actives sample the pre-write shadow, so a duty write landing on the wrap edge waits a period.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (duty_wr && (duty_idx == 2'(i))) begin
        shadow_d[i] = wdata[PWM_BITS:0];
      end
      if (!en_q || wrap) begin
        active_d[i] = shadow_q[i];
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (!en_q) begin
      pending_d = 1'b0;
    end else if (duty_wr) begin
      pending_d = 1'b1;
    end else if (wrap) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NCH; i++) begin
      out_d[i] = en_q && ({1'b0, cnt_q} < active_q[i]);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (word)
        OFF_CTRL:     rdata_d[0] = en_q;
        OFF_PRESCALE: rdata_d[PRESCALE_W-1:0] = prescale_q;
        OFF_DUTY_LED, OFF_DUTY_R, OFF_DUTY_G, OFF_DUTY_B:
                      rdata_d[PWM_BITS:0] = shadow_q[duty_idx];
        OFF_STATUS: begin
          rdata_d[0]    = pending_q;
          rdata_d[15:8] = status_cnt;
        end
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      out_q      <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign rdata = rdata_q;
  assign led   = out_q[0];
  assign red   = out_q[1];
  assign green = out_q[2];
  assign blue  = out_q[3];

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Scoreboard bench for mmio_pwm_led: stimulus queues expected read data and
// per-window PWM high counts; the negedge monitor pops and compares.
module tb_mmio_pwm_led;

  localparam logic [31:0] BASE       = 32'h0000_2000;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
  localparam logic [31:0] A_DLED     = BASE + 32'h08;
  localparam logic [31:0] A_DR       = BASE + 32'h0C;
  localparam logic [31:0] A_DG       = BASE + 32'h10;
  localparam logic [31:0] A_DB       = BASE + 32'h14;
  localparam logic [31:0] A_STATUS   = BASE + 32'h18;
  localparam logic [31:0] A_RSVD     = BASE + 32'h1C;

  localparam logic [3:0] M_LED = 4'b0001;
  localparam logic [3:0] M_RED = 4'b0010;
  localparam logic [3:0] M_GRN = 4'b0100;
  localparam logic [3:0] M_BLU = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        led, red, green, blue;
  logic [3:0]  outs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cyc = 0;

  logic rd_issue = 1'b0;
  logic rd_vld   = 1'b0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic        sel_exp_q[$];
  string       sel_name_q[$];
  logic [3:0]  win_mask_q[$];
  int          win_n_q[$];
  int          win_exp_q[$];
  string       win_name_q[$];

  bit win_active = 1'b0;
  int win_rem    = 0;
  int win_acc    = 0;

  assign outs = {blue, green, red, led};

  mmio_pwm_led #(
    .BASE_ADDR (BASE),
    .PWM_BITS  (8),
    .PRESCALE_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .sel  (sel),
    .rdata(rdata),
    .led  (led),
    .red  (red),
    .green(green),
    .blue (blue)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_issue;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sel is checked in the issue cycle, rdata one cycle later, windows count high cycles.
  always @(negedge clk) begin
    if (rd_issue) begin
      if (sel_exp_q.size() == 0) begin
        chk("sel_queue_underflow", 32'd1, 32'd0);
      end else begin
        chk(sel_name_q.pop_front(), 32'(sel), 32'(sel_exp_q.pop_front()));
      end
    end
    if (rd_vld) begin
      if (rd_exp_q.size() == 0) begin
        chk("rd_queue_underflow", 32'd1, 32'd0);
      end else begin
        chk(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
      end
    end
    if (!win_active && win_n_q.size() != 0) begin
      win_active = 1'b1;
      win_rem    = win_n_q[0];
      win_acc    = 0;
    end
    if (win_active) begin
      if ((outs & win_mask_q[0]) != 4'b0000) win_acc++;
      win_rem--;
      if (win_rem == 0) begin
        chk(win_name_q.pop_front(), 32'(win_acc), 32'(win_exp_q.pop_front()));
        void'(win_mask_q.pop_front());
        void'(win_n_q.pop_front());
        win_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [31:0] exp, input logic exp_sel, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    sel_exp_q.push_back(exp_sel);
    sel_name_q.push_back({name, "_sel"});
    addr     = a;
    wdata    = d;
    we       = w;
    rd_issue = 1'b1;
    step();
    rd_issue = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_sel, input string name);
    acc(a, 32'h0, 1'b0, exp, exp_sel, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic win(input logic [3:0] m, input int n, input int exp, input string name);
    win_mask_q.push_back(m);
    win_n_q.push_back(n);
    win_exp_q.push_back(exp);
    win_name_q.push_back(name);
  endtask

  // Model of the PWM count in the current cycle, valid while EN=1 and PRESCALE=0.
  task automatic wait_cnt(input int v);
    for (int g = 0; g < 256 && ((cyc - en_cyc) % 256) != v; g++) step();
  endtask

  task automatic next_period_start();
    step();
    wait_cnt(0);
    step();
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while ((win_n_q.size() != 0 || rd_exp_q.size() != 0 || sel_exp_q.size() != 0) && g < budget) begin
      step();
      g++;
    end
    if (g >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d windows and %0d reads still pending, expected none",
               win_n_q.size(), rd_exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges with a CTRL store pending.
    reset = 1'b0;
    addr  = A_CTRL;
    wdata = 32'h1;
    we    = 1'b1;
    step();
    win(M_ALL, 2, 0, "rst_outputs");
    acc(A_CTRL, 32'h1, 1'b1, 32'h0, 1'b1, "rst_rdata");
    reset = 1'b1;
    rd(A_STATUS, 32'h0, 1'b1, "rst_status");
    rd(A_CTRL,   32'h0, 1'b1, "rst_ctrl");

    // Red at 64/256, prescale 0.
    wr(A_PRESCALE, 32'd0);
    wr(A_DR, 32'd64);
    rd(A_DR, 32'd64, 1'b1, "duty_r_readback");
    wr(A_CTRL, 32'h1);
    en_cyc = cyc;
    win(M_RED, 1, 0, "red_first_cycle_low");
    win(M_RED, 1, 1, "red_second_cycle_high");
    win(M_RED, 256, 64, "red_duty64");
    win(M_LED | M_GRN | M_BLU, 256, 0, "others_off");
    wait_idle(1000);

    // Duty 0 and full-scale duty.
    wr(A_DG, 32'd0);
    wr(A_DB, 32'd256);
    next_period_start();
    win(M_GRN, 768, 0, "green_duty0");
    win(M_BLU, 768, 768, "blue_duty256");
    wait_idle(2000);

    // Mid-period duty update only takes effect at the next wrap.
    next_period_start();
    win(M_RED, 256, 64, "red_old_period");
    win(M_RED, 256, 200, "red_new_period");
    wait_cnt(10);
    wr(A_DR, 32'd200);
    rd(A_STATUS, 32'h0000_0B01, 1'b1, "pending_set");
    wait_cnt(255);
    rd(A_STATUS, 32'h0000_FF01, 1'b1, "pending_held");
    rd(A_STATUS, 32'h0000_0000, 1'b1, "pending_cleared_at_wrap");
    wait_idle(1000);

    // Duty write on the wrap edge itself.
    wait_cnt(255);
    wr(A_DLED, 32'd128);
    rd(A_STATUS, 32'h0000_0001, 1'b1, "pending_wrap_collision");
    win(M_LED, 256, 0, "led_old_at_wrap");
    win(M_LED, 256, 128, "led_new_duty128");
    wait_idle(1000);

    // Prescale 3: count advances every 4 cycles; rewriting restarts the prescaler.
    wait_cnt(0);
    wr(A_PRESCALE, 32'd3);
    for (int i = 0; i < 4; i++) rd(A_STATUS, 32'h0000_0100, 1'b1, "presc_hold_cnt1");
    rd(A_STATUS, 32'h0000_0200, 1'b1, "presc_step_cnt2");
    wr(A_PRESCALE, 32'd3);
    for (int i = 0; i < 4; i++) rd(A_STATUS, 32'h0000_0200, 1'b1, "presc_restart_hold");
    rd(A_STATUS, 32'h0000_0300, 1'b1, "presc_restart_step");
    win(M_RED, 1024, 800, "red_presc_period");
    win(M_LED, 1024, 512, "led_presc_period");
    rd(A_CTRL,     32'h1,   1'b1, "ctrl_readback");
    rd(A_PRESCALE, 32'h3,   1'b1, "prescale_readback");
    rd(A_DB,       32'h100, 1'b1, "duty_b_readback");
    rd(A_RSVD,     32'h0,   1'b1, "reserved_reads_zero");
    rd(BASE + 32'h20, 32'h0, 1'b0, "above_window");
    rd(BASE - 32'h4,  32'h0, 1'b0, "below_window");
    wait_idle(3000);

    // Disable forces outputs low; STATUS is read-only.
    wr(A_CTRL, 32'h0);
    step();
    win(M_ALL, 20, 0, "disabled_outputs_off");
    rd(A_STATUS, 32'h0, 1'b1, "status_disabled");
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, 32'h0, 1'b1, "status_write_ignored");
    wait_idle(200);

    // Reset in the middle of a running period.
    wr(A_CTRL, 32'h1);
    repeat (37) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(A_CTRL,   32'h0, 1'b1, "midrst_ctrl");
    rd(A_DR,     32'h0, 1'b1, "midrst_duty_r");
    rd(A_STATUS, 32'h0, 1'b1, "midrst_status");
    win(M_ALL, 8, 0, "midrst_outputs_off");
    wait_idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
